// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the radio-link UART (receiver and transmitter).
// Latency: n/a (definitions only).
// Backpressure: n/a.
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  // 10 MHz system clock / 9600 baud
  localparam int UART_CLKS_PER_BIT = 1042;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } uart_rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// uart_sync: N-flop synchronizer for asynchronous pins, with a selectable reset value.
// Latency: STAGES clocks from d_i to q_o.
// Backpressure: none; samples every clock.
// Ports: clk, nRst (async active-low), rst_val_i (value loaded into every flop on reset),
//        d_i (asynchronous input), q_o (synchronized output).
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic nRst,
  input  logic rst_val_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      sync_q <= {STAGES{rst_val_i}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_msg_rx.sv
// uart_msg_rx: 8N1 serial receiver (8E1 when UART_RX_PARITY_EN is defined) holding one byte for the game logic.
// Latency: rx_valid / error pulses 1 clock after the stop-bit mid-sample (~9.5 bits + SYNC_STAGES + 1 clocks after the start edge).
// Backpressure: none on the line; an unacknowledged byte is overwritten by the next one and overrun pulses.
// Ports: clk, nRst (async active-low), rx_serial (async line, idle high), msg_ack (clears rx_valid),
//        rx_data/rx_valid (held byte), busy (frame in progress), framing_error/parity_error/overrun (1-clock pulses).
module uart_msg_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                      clk,
  input  logic                      nRst,
  input  logic                      rx_serial,
  input  logic                      msg_ack,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  output logic                      busy,
  output logic                      framing_error,
  output logic                      parity_error,
  output logic                      overrun
);

  localparam int             CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]     LAST = 3'(UART_DATA_BITS - 1);

  logic rx_s;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .nRst      (nRst),
    .rst_val_i (1'b1),
    .d_i       (rx_serial),
    .q_o       (rx_s)
  );

  // The synchronizer comes out of reset holding 1s, so a line held low through
  // reset release would look like a falling edge. prime_q marks when the chain
  // carries real line samples; rx_prev_q only starts tracking rx_s after that,
  // so a start edge needs the line to have actually been seen high.
  logic [SYNC_STAGES-1:0] prime_q;
  logic                   rx_prev_q;

  uart_rx_state_t            state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [2:0]                idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      fe_q, fe_d;
  logic                      ov_q, ov_d;
`ifdef UART_RX_PARITY_EN
  logic                      par_err_q, par_err_d;
  logic                      pe_q, pe_d;
`endif

  logic tick;
  assign tick = (cnt_q == '0);

  // State register
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      prime_q   <= '0;
      rx_prev_q <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
      pe_q      <= 1'b0;
`endif
    end else begin
      prime_q   <= {prime_q[SYNC_STAGES-2:0], 1'b1};
      rx_prev_q <= rx_s & prime_q[SYNC_STAGES-1];
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
`ifdef UART_RX_PARITY_EN
      par_err_q <= par_err_d;
      pe_q      <= pe_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = 1'b0;
    ov_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
    pe_d      = 1'b0;
`endif

    // Bit timer runs only while a frame is being timed; reload instead of wrapping.
    if (state_q != IDLE && state_q != WAIT_HIGH) begin
      cnt_d = tick ? FULL : cnt_q - CW'(1);
    end

    if (msg_ack && valid_q) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s) begin
          state_d = START;
          cnt_d   = HALF;
        end
      end
      START: begin
        if (tick) begin
          if (!rx_s) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shreg_d = {rx_s, shreg_q[UART_DATA_BITS-1:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          par_err_d = rx_s ^ (^shreg_q);
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (!rx_s) begin
            fe_d    = 1'b1;
            state_d = WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
          end else if (par_err_q) begin
            pe_d    = 1'b1;
            state_d = IDLE;
`endif
          end else begin
            // Commit overrides a same-cycle ack; overrun only if the old byte was never taken.
            data_d  = shreg_q;
            valid_d = 1'b1;
            ov_d    = valid_q && !msg_ack;
            state_d = IDLE;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q != IDLE);
  end

  assign rx_data       = data_q;
  assign rx_valid      = valid_q;
  assign framing_error = fe_q;
  assign overrun       = ov_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error  = pe_q;
`else
  assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_msg_rx.sv
// tb_uart_msg_rx: directed bench for uart_msg_rx at 16 clocks per bit.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_msg_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 171;  // 2 sync + 1 edge + 8 half-bit + 10 bits * 16
`else
  localparam int LAT = 155;  // 2 sync + 1 edge + 8 half-bit + 9 bits * 16
`endif

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       rx_serial = 1'b1;
  logic       msg_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, busy, framing_error, parity_error, overrun;

  always #5 clk = ~clk;

  uart_msg_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .nRst          (nRst),
    .rx_serial     (rx_serial),
    .msg_ack       (msg_ack),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .busy          (busy),
    .framing_error (framing_error),
    .parity_error  (parity_error),
    .overrun       (overrun)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_cmp = 0, n_bad = 0;
  int   fe_n = 0, pe_n = 0, ov_n = 0, vrise_n = 0, vrise_cyc = 0, start_cyc = 0;
  logic v_prev = 1'b0;

  always @(negedge clk) begin
    if (framing_error) fe_n++;
    if (parity_error)  pe_n++;
    if (overrun)       ov_n++;
    if (rx_valid && !v_prev) begin
      vrise_n++;
      vrise_cyc = cyc;
    end
    v_prev = rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge once the stop bit has been fully sent.
  task automatic send_byte(input logic [7:0] b, input logic par_flip, input int stop_low, input logic ack_commit);
    start_cyc = cyc;
    rx_serial = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx_serial = (^b) ^ par_flip;
    repeat (CPB) @(negedge clk);
`endif
    if (stop_low > 0) begin
      rx_serial = 1'b0;
      repeat (CPB * stop_low) @(negedge clk);
    end
    rx_serial = 1'b1;
    // Stop-bit sample lands 10 clocks into the stop bit; ack there hits the commit cycle.
    for (int i = 0; i < CPB; i++) begin
      msg_ack = (ack_commit && stop_low == 0 && i == 10);
      @(negedge clk);
    end
    msg_ack = 1'b0;
  endtask

  task automatic ack_pulse();
    msg_ack = 1'b1;
    @(negedge clk);
    msg_ack = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_data",  rx_data, 8'h00);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_busy",  busy, 1'b0);
    chk("rst_fe",    framing_error, 1'b0);
    chk("rst_pe",    parity_error, 1'b0);
    chk("rst_ov",    overrun, 1'b0);
    repeat (3) @(negedge clk);
    nRst = 1'b1;
    repeat (6) @(negedge clk);

    // 'A', no ack: latency and hold
    send_byte(8'h41, 1'b0, 0, 1'b0);
    chk("A_latency", vrise_cyc - start_cyc, LAT);
    chk("A_data",    rx_data, 8'h41);
    chk("A_valid",   rx_valid, 1'b1);
    chk("A_busy",    busy, 1'b0);
    chk("A_ov",      ov_n, 0);
    ack_pulse();
    chk("A_ack_valid", rx_valid, 1'b0);
    chk("A_ack_data",  rx_data, 8'h41);

    // 3-clock low glitch
    rx_serial = 1'b0;
    repeat (3) @(negedge clk);
    rx_serial = 1'b1;
    chk("glitch_busy_hi", busy, 1'b1);
    repeat (20) @(negedge clk);
    chk("glitch_busy_lo", busy, 1'b0);
    chk("glitch_valid",   rx_valid, 1'b0);
    chk("glitch_vrise",   vrise_n, 1);
    chk("glitch_fe",      fe_n, 0);

    // 'P' with stop held low for 2 bit times, then 'L'
    send_byte(8'h50, 1'b0, 2, 1'b0);
    chk("frm_fe",    fe_n, 1);
    chk("frm_valid", rx_valid, 1'b0);
    chk("frm_vrise", vrise_n, 1);
    repeat (4) @(negedge clk);
    send_byte(8'h4C, 1'b0, 0, 1'b0);
    chk("frm_L_data",  rx_data, 8'h4C);
    chk("frm_L_valid", rx_valid, 1'b1);
    chk("frm_L_fe",    fe_n, 1);
    ack_pulse();

    // Overrun: back-to-back with no ack
    send_byte(8'h50, 1'b0, 0, 1'b0);
    chk("ovr_P_data", rx_data, 8'h50);
    send_byte(8'h4C, 1'b0, 0, 1'b0);
    chk("ovr_count", ov_n, 1);
    chk("ovr_data",  rx_data, 8'h4C);
    chk("ovr_valid", rx_valid, 1'b1);
    ack_pulse();
    // Ack on the commit cycle: commit wins, no overrun
    send_byte(8'h50, 1'b0, 0, 1'b0);
    send_byte(8'h4C, 1'b0, 0, 1'b1);
    chk("coin_ov",    ov_n, 1);
    chk("coin_valid", rx_valid, 1'b1);
    chk("coin_data",  rx_data, 8'h4C);

    // Reset during data bit 4 of 'E' with the line low (rx_valid still set from 'L')
    start_cyc = cyc;
    rx_serial = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_serial = (8'h45 >> i) & 8'h01;
      repeat (CPB) @(negedge clk);
    end
    rx_serial = 1'b0;
    repeat (5) @(negedge clk);
    nRst = 1'b0;
    #1;
    chk("mid_rst_data",  rx_data, 8'h00);
    chk("mid_rst_valid", rx_valid, 1'b0);
    chk("mid_rst_busy",  busy, 1'b0);
    repeat (3) @(negedge clk);
    nRst = 1'b1;
    repeat (40) @(negedge clk);
    chk("low_rel_busy",  busy, 1'b0);
    chk("low_rel_valid", rx_valid, 1'b0);
    rx_serial = 1'b1;
    repeat (10) @(negedge clk);
    send_byte(8'h45, 1'b0, 0, 1'b0);
    chk("E_data",  rx_data, 8'h45);
    chk("E_valid", rx_valid, 1'b1);
    chk("E_ov",    ov_n, 1);
    ack_pulse();

`ifdef UART_RX_PARITY_EN
    send_byte(8'h41, 1'b1, 0, 1'b0);
    chk("par_bad_pe",    pe_n, 1);
    chk("par_bad_valid", rx_valid, 1'b0);
    send_byte(8'h41, 1'b0, 0, 1'b0);
    chk("par_ok_pe",    pe_n, 1);
    chk("par_ok_data",  rx_data, 8'h41);
    chk("par_ok_valid", rx_valid, 1'b1);
`else
    chk("nopar_pe", pe_n, 0);
`endif
    chk("final_fe", fe_n, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
